// File: rtl/vga_frame_sig.sv
// ---------------------------------------------------------------------------
// vga_frame_sig
//
// Frame signature analyzer on the consuming side of the VGA pixel stream.
// After a single-cycle arm it waits for the next start of frame (DE pixel at
// x==0, y==0), folds every DE-qualified rgb value of that frame into a
// CCITT CRC-16 (poly 0x1021, non-reflected, no final XOR, 12 bits per pixel
// MSB first), counts the pixels and tracks raster geometry.  After the frame
// ends the results are latched and sig_valid pulses for one cycle.
//
// Parameters
//   H_ACTIVE   active pixels per line
//   V_ACTIVE   active lines per frame
//   CRC_INIT   CRC seed loaded at start of frame
//
// Ports
//   clk        pixel clock
//   reset      asynchronous, active-high reset
//   x, y       pixel column / row from the timing generator
//   DE         active-video qualifier
//   rgb        pixel colour {R[3:0],G[3:0],B[3:0]}
//   arm        single-cycle capture request (honoured only when idle)
//   golden     expected signature (used only with VGA_SIG_GOLDEN_EN)
//   busy       high while waiting for SOF or capturing
//   sig_valid  one-cycle pulse when the result outputs update
//   sig        CRC of the last captured frame
//   pix_count  DE pixels in the last captured frame (saturating)
//   err_geom   last frame had a geometry error
//   match      sig == golden and no geometry error (0 without the macro)
//
// Build option
//   VGA_SIG_GOLDEN_EN  compiles in the golden comparator; otherwise match
//                      is tied low and golden is ignored.
// ---------------------------------------------------------------------------
module vga_frame_sig #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        DE,
  input  logic [11:0] rgb,
  input  logic        arm,
  input  logic [15:0] golden,
  output logic        busy,
  output logic        sig_valid,
  output logic [15:0] sig,
  output logic [18:0] pix_count,
  output logic        err_geom,
  output logic        match
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_CAPTURE  = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [18:0] FRAME_PIX = 19'(H_ACTIVE * V_ACTIVE);

  // Twelve CRC-16/CCITT steps unrolled, rgb[11] (R[3]) enters first.
  function automatic logic [15:0] crc16_fold12(input logic [15:0] c_in,
                                               input logic [11:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [18:0] sat_inc19(input logic [18:0] c);
    return (&c) ? c : c + 19'd1;
  endfunction

  logic [1:0]  state, state_nxt;
  logic [15:0] crc_p0;
  logic [18:0] cnt_p0;
  logic        geom_p0;
  logic [9:0]  px_p0, py_p0;

  logic        sof, eof, out_of_range, not_succ, frame_err;
  logic [9:0]  exp_x, exp_y;
  logic [15:0] crc_nxt;

  assign sof          = DE && (x == 10'd0) && (y == 10'd0);
  assign eof          = DE && (x == X_LAST) && (y == Y_LAST);
  assign out_of_range = (x > X_LAST) || (y > Y_LAST);

  // Raster successor of the previously folded pixel.
  assign exp_x    = (px_p0 == X_LAST) ? 10'd0 : px_p0 + 10'd1;
  assign exp_y    = (px_p0 == X_LAST) ? py_p0 + 10'd1 : py_p0;
  assign not_succ = (x != exp_x) || (y != exp_y);

  // The SOF pixel folds onto the seed, later pixels onto the running CRC.
  assign crc_nxt   = crc16_fold12((state == S_WAIT_SOF) ? CRC_INIT : crc_p0, rgb);
  assign frame_err = geom_p0 || (cnt_p0 != FRAME_PIX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (arm) state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: if (sof) state_nxt = eof ? S_DONE : S_CAPTURE;
      S_CAPTURE:  if (sof || eof) state_nxt = S_DONE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: frame accumulation (loaded at SOF, no reset needed) ----
  always_ff @(posedge clk) begin
    if (state == S_WAIT_SOF && sof) begin
      crc_p0  <= crc_nxt;
      cnt_p0  <= 19'd1;
      geom_p0 <= 1'b0;
      px_p0   <= x;
      py_p0   <= y;
    end else if (state == S_CAPTURE && DE) begin
      if (sof) begin
        // A new frame started before EOF: close this one as broken and
        // leave the SOF pixel unfolded.
        geom_p0 <= 1'b1;
      end else begin
        crc_p0  <= crc_nxt;
        cnt_p0  <= sat_inc19(cnt_p0);
        geom_p0 <= geom_p0 | out_of_range | not_succ;
        px_p0   <= x;
        py_p0   <= y;
      end
    end
  end

  // ---- stage p1: control and registered result outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      sig       <= 16'h0000;
      pix_count <= 19'd0;
      err_geom  <= 1'b0;
`ifdef VGA_SIG_GOLDEN_EN
      match     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == S_WAIT_SOF) || (state_nxt == S_CAPTURE);
      sig_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        sig       <= crc_p0;
        pix_count <= cnt_p0;
        err_geom  <= frame_err;
`ifdef VGA_SIG_GOLDEN_EN
        match     <= (crc_p0 == golden) && !frame_err;
`endif
      end
    end
  end

`ifndef VGA_SIG_GOLDEN_EN
  logic unused_golden;
  assign unused_golden = ^golden;
  assign match         = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_sig.sv
module tb_vga_frame_sig;
  localparam int H = 4;
  localparam int V = 2;
  localparam logic [9:0] XL = 10'(H - 1);
  localparam logic [9:0] YL = 10'(V - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        DE;
  logic [11:0] rgb;
  logic        arm;
  logic [15:0] golden;
  logic        busy, sig_valid;
  logic [15:0] sig;
  logic [18:0] pix_count;
  logic        err_geom, match;

  int checks = 0;
  int errors = 0;

  vga_frame_sig #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .DE(DE), .rgb(rgb), .arm(arm),
    .golden(golden), .busy(busy), .sig_valid(sig_valid), .sig(sig),
    .pix_count(pix_count), .err_geom(err_geom), .match(match)
  );

  always #5 clk = ~clk;

  // Reference model: pixels of the frame being captured, plus expected outputs.
  typedef struct packed {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] c;
  } pix_t;

  pix_t        fq[$];
  int          phase;          // 0 idle, 1 waiting for SOF, 2 capturing, 3 frame ended
  bit          done_pending;
  logic [15:0] pend_crc;
  logic [18:0] pend_cnt;
  bit          pend_err;
  int          golden_mode;    // 0 leave golden, 1 drive model CRC, 2 model CRC ^ 1
  logic        exp_busy, exp_valid, exp_err, exp_match;
  logic [15:0] exp_sig;
  logic [18:0] exp_cnt;

  function automatic logic [15:0] crc_of_frame();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (fq[k]) begin
      for (int b = 11; b >= 0; b--) begin
        fb = c[15] ^ fq[k].c[b];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // The k-th pixel of a clean frame sits at (k % H, k / H).
  task automatic finish_frame(input bit aborted);
    pend_crc = crc_of_frame();
    pend_cnt = 19'(fq.size());
    pend_err = aborted || (fq.size() != H * V);
    foreach (fq[k])
      if (fq[k].px != 10'(k % H) || fq[k].py != 10'(k / H)) pend_err = 1'b1;
    done_pending = 1'b1;
    phase = 3;
  endtask

  task automatic model_reset();
    phase = 0; done_pending = 1'b0; fq.delete();
    exp_busy = 0; exp_valid = 0; exp_sig = 16'h0; exp_cnt = 19'd0;
    exp_err = 0; exp_match = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs();
    chk("busy",      32'(busy),      32'(exp_busy));
    chk("sig_valid", 32'(sig_valid), 32'(exp_valid));
    chk("sig",       32'(sig),       32'(exp_sig));
    chk("pix_count", 32'(pix_count), 32'(exp_cnt));
    chk("err_geom",  32'(err_geom),  32'(exp_err));
    chk("match",     32'(match),     32'(exp_match));
  endtask

  // One clock: drive inputs, advance the model for this edge, check outputs.
  task automatic step(input logic [9:0] sx, input logic [9:0] sy, input logic sde,
                      input logic [11:0] sc, input logic sarm);
    pix_t p;
    x = sx; y = sy; DE = sde; rgb = sc; arm = sarm;
    if (done_pending && golden_mode != 0)
      golden = pend_crc ^ ((golden_mode == 2) ? 16'h0001 : 16'h0000);
    @(posedge clk);
    exp_valid = 1'b0;
    p.px = sx; p.py = sy; p.c = sc;
    if (done_pending) begin
      done_pending = 1'b0;
      exp_valid = 1'b1;
      exp_sig = pend_crc; exp_cnt = pend_cnt; exp_err = pend_err;
`ifdef VGA_SIG_GOLDEN_EN
      exp_match = (pend_crc == golden) && !pend_err;
`else
      exp_match = 1'b0;
`endif
      phase = 0;
    end else if (phase == 0) begin
      if (sarm) phase = 1;
    end else if (phase == 1) begin
      if (sde && sx == 10'd0 && sy == 10'd0) begin
        fq.delete(); fq.push_back(p); phase = 2;
      end
    end else if (phase == 2 && sde) begin
      if (sx == 10'd0 && sy == 10'd0) finish_frame(1'b1);
      else begin
        fq.push_back(p);
        if (sx == XL && sy == YL) finish_frame(1'b0);
      end
    end
    exp_busy = (phase == 1) || (phase == 2);
    #1;
    chk_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                    1'b0, 12'($urandom), 1'b0);
  endtask

  function automatic logic [11:0] bar_colour(input int xx);
    case (xx % 4)
      0:       return 12'hF00;
      1:       return 12'h0F0;
      2:       return 12'h00F;
      default: return 12'hFFF;
    endcase
  endfunction

  // kind: 0 black, 1 random, 2 skip (2,0), 3 x=5 at (3,0), 4 SOF after 5 pixels,
  //       5 colour bars, 6 black with F00 at pixel 5
  task automatic raster(input int kind, input bit arm_first);
    logic [9:0]  px, py;
    logic        de;
    logic [11:0] c;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        int k = yy * H + xx;
        px = 10'(xx); py = 10'(yy); de = 1'b1;
        case (kind)
          1:       c = 12'($urandom);
          5:       c = bar_colour(xx);
          6:       c = (k == 5) ? 12'hF00 : 12'h000;
          default: c = 12'h000;
        endcase
        if (kind == 2 && xx == 2 && yy == 0) de = 1'b0;
        if (kind == 3 && xx == 3 && yy == 0) px = 10'd5;
        if (kind == 4 && k == 5) begin
          step(10'd0, 10'd0, 1'b1, c, 1'b0);
          return;
        end
        if (!(arm_first && k == 0) && $urandom_range(0, 3) == 0) idle(1);
        step(px, py, de, c, arm_first && k == 0);
      end
      idle(2);
    end
  endtask

  task automatic armed_frame(input int kind);
    step(10'd0, 10'd0, 1'b0, 12'h000, 1'b1);
    chk("busy_after_arm", 32'(busy), 32'd1);
    idle(2);
    raster(kind, 1'b0);
    idle(4);
  endtask

  logic [15:0] sig_black, sig_red, sig_bar0, sig_bar1, sig_bar2;

  initial begin
    reset = 1'b1; x = 10'd0; y = 10'd0; DE = 1'b0; rgb = 12'h000; arm = 1'b0;
    golden = 16'h0000; golden_mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs();
    reset = 1'b0;
    idle(3);

    // Black frame
    armed_frame(0);
    chk("black_cnt", 32'(pix_count), 32'd8);
    chk("black_err", 32'(err_geom), 32'd0);
    sig_black = sig;

    // Same frame with one red pixel
    armed_frame(6);
    sig_red = sig;
    chk("red_differs", 32'(sig_red != sig_black), 32'd1);

    // Random colours
    armed_frame(1);
    armed_frame(1);

    // Skipped pixel (2,0)
    armed_frame(2);
    chk("skip_cnt", 32'(pix_count), 32'd7);
    chk("skip_err", 32'(err_geom), 32'd1);

    // x out of range with DE high
    armed_frame(3);
    chk("xrange_err", 32'(err_geom), 32'd1);

    // SOF reappears after 5 pixels
    armed_frame(4);
    chk("resof_cnt", 32'(pix_count), 32'd5);
    chk("resof_err", 32'(err_geom), 32'd1);

    // Reset in the middle of a capture
    step(10'd0, 10'd0, 1'b0, 12'h000, 1'b1);
    step(10'd0, 10'd0, 1'b1, 12'h123, 1'b0);
    step(10'd1, 10'd0, 1'b1, 12'h456, 1'b0);
    step(10'd2, 10'd0, 1'b1, 12'h789, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    chk_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    armed_frame(1);
    chk("post_reset_cnt", 32'(pix_count), 32'd8);

    // Golden comparison
    golden_mode = 1;
    armed_frame(1);
`ifdef VGA_SIG_GOLDEN_EN
    chk("golden_hit", 32'(match), 32'd1);
`else
    chk("golden_hit", 32'(match), 32'd0);
`endif
    golden_mode = 2;
    armed_frame(1);
    chk("golden_miss", 32'(match), 32'd0);
    golden_mode = 0;

    // Arm coinciding with an SOF pixel: that frame is skipped, next one captured
    raster(0, 1'b1);
    chk("arm_on_sof_busy", 32'(busy), 32'd1);
    raster(5, 1'b0);
    idle(4);
    chk("arm_on_sof_cnt", 32'(pix_count), 32'd8);
    sig_bar0 = sig;

    // Colour bars on consecutive armed frames give the same signature
    armed_frame(5);
    sig_bar1 = sig;
    armed_frame(5);
    sig_bar2 = sig;
    chk("bar_stable_1", 32'(sig_bar1), 32'(sig_bar0));
    chk("bar_stable_2", 32'(sig_bar2), 32'(sig_bar0));
    chk("bar_err", 32'(err_geom), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_frame_sig.md
# vga_frame_sig

Frame signature analyzer on the consuming side of the VGA pixel stream. Samples the active-video pixels (`x`, `y`, `DE`, `rgb`) that the pattern source and timing generator drive toward the DAC. Folds one armed frame into a CRC-16 signature and a pixel count, then reports geometry errors and, optionally, a golden-signature match. Used in simulation and on-board self-test to prove the generated image is bit-exact without a monitor.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `CRC_INIT`, 16'hFFFF, CRC seed loaded at start of frame
- `clk`  input  1  pixel clock
- `reset`  input  1  asynchronous, active-high reset
- `x`  input  10  pixel column from timing generator
- `y`  input  10  pixel row from timing generator
- `DE`  input  1  active-video qualifier; pixel sampled only when high
- `rgb`  input  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- `arm`  input  1  single-cycle request to capture the next full frame
- `golden`  input  16  expected signature (used only with `VGA_SIG_GOLDEN_EN`)
- `busy`  output  1  high in WAIT_SOF and CAPTURE
- `sig_valid`  output  1  one-cycle pulse when results update
- `sig`  output  16  CRC of the last captured frame
- `pix_count`  output  19  DE-qualified pixels in the last captured frame
- `err_geom`  output  1  last frame had a geometry error
- `match`  output  1  `sig == golden` and `!err_geom` for the last frame

## Operation
- FSM states: IDLE, WAIT_SOF, CAPTURE, DONE. All outputs registered.
- IDLE: `arm`=1 → WAIT_SOF. `arm` in any other state is ignored.
- WAIT_SOF: the first cycle with `DE && x==0 && y==0` is start of frame (SOF). On SOF:
  - CRC ← `CRC_INIT` folded with that pixel.
  - count ← 1.
  - → CAPTURE.
- CAPTURE: each `DE` cycle folds `rgb` into the CRC and increments the count.
- CRC: CCITT polynomial 0x1021, non-reflected, no final XOR. The 12 `rgb` bits are folded MSB (R[3]) first, all in one cycle, unrolled combinationally.
- Geometry error flag sets if either occurs:
  - a `DE` pixel has `x >= H_ACTIVE` or `y >= V_ACTIVE`;
  - a `DE` pixel's (x,y) is not the raster successor of the previous one (x+1 on the same line, or x=0 and y+1 after x=H_ACTIVE-1).
- End of frame (EOF): the `DE` pixel with `x==H_ACTIVE-1 && y==V_ACTIVE-1`, folded normally → DONE.
- Second SOF pixel while in CAPTURE:
  - the frame ends, with `err_geom` forced to 1;
  - the SOF pixel is not folded;
  - → DONE.
- DONE (one cycle):
  - latch `sig`, `pix_count` and `err_geom`; compute `match`;
  - pulse `sig_valid`;
  - → IDLE.
- `pix_count` must equal `H_ACTIVE*V_ACTIVE`. Any other value also forces `err_geom`=1.
- The count saturates at 2^19-1.

## Timing
- Reset values: state IDLE; `busy`=0, `sig_valid`=0, `sig`=16'h0000, `pix_count`=0, `err_geom`=0, `match`=0.
- Reset mid-capture discards the partial frame immediately. No `sig_valid` is produced.
- `arm` sampled at edge N → `busy`=1 from N+1.
- If an SOF pixel is sampled at N+1, CAPTURE starts then. An `arm` coinciding with an SOF pixel does not capture that frame; capture waits for the next SOF.
- EOF pixel sampled at edge E:
  - DONE at E+1;
  - `sig`, `pix_count`, `err_geom`, `match` and `sig_valid` visible after edge E+1;
  - `busy` low from E+1.
- Result outputs hold until the next DONE.
- `DE` low cycles (blanking) leave the CRC, count and FSM unchanged.

## Configuration
- `VGA_SIG_GOLDEN_EN` defined: golden comparator compiled in; `match` is registered in DONE.
- Not defined: no comparator logic; `match` is tied 0; the `golden` port remains but is unused.

## Test plan
- Parameters H_ACTIVE=4, V_ACTIVE=2, raster with blanking gaps, all rgb=12'h000, arm once:
  - `sig_valid` pulses once, 1 cycle after pixel (3,1);
  - `pix_count`=8, `err_geom`=0;
  - `sig` equals the bench's bit-serial CRC model.
- Same frame run twice with `rgb=12'hF00` at one pixel: the two signatures differ; each matches the model.
- Pixel (2,0) skipped (DE low): `pix_count`=7, `err_geom`=1.
- Pixel with x=5 while DE=1: `err_geom`=1.
- SOF reappears after 5 pixels: DONE 1 cycle later, `pix_count`=5, `err_geom`=1.
- `reset` pulsed during CAPTURE: all outputs return to reset values and there is no `sig_valid`. A fresh arm then yields a correct result.
- With `VGA_SIG_GOLDEN_EN`, `golden` set to the model CRC: `match`=1. With `golden` XOR 16'h0001: `match`=0. Built without the macro: `match`=0 always.
- Full 640x480 run driven by the colour-bar source: `pix_count`=307200, `err_geom`=0, and `sig` is identical across 3 consecutive armed frames.
